// File: rtl/univ_shift_nbit.sv
// univ_shift_nbit: N-bit universal register (hold / shift right / shift left /
// parallel load) with a counted burst-shift mode reporting busy and done.
module univ_shift_nbit #(
   parameter int unsigned N  = 16,
   parameter int unsigned CW = $clog2(N+1)
) (
   input  logic          clk,
   input  logic          reset_ah_in,
   input  logic          en_in,
   input  logic [1:0]    mode_in,
   input  logic [N-1:0]  d_in,
   input  logic          sin_msb_in,
   input  logic          sin_lsb_in,
   input  logic          start_in,
   input  logic [CW-1:0] count_in,
   output logic [N-1:0]  q_out,
   output logic          sout_lsb_out,
   output logic          sout_msb_out,
   output logic          busy_out,
   output logic          done_out
);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   typedef enum logic [1:0] {
      M_HOLD  = 2'b00,
      M_RIGHT = 2'b01,
      M_LEFT  = 2'b10,
      M_LOAD  = 2'b11
   } mode_t;

   state_t        state, state_nxt;
   logic [N-1:0]  q_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          dir_left, dir_left_nxt;
   logic          busy_nxt, done_nxt;
   logic [N-1:0]  q_shr, q_shl;
   logic [CW-1:0] count_clamped;
   logic          shift_mode;

   assign q_shr         = {sin_msb_in, q_out[N-1:1]};
   assign q_shl         = {q_out[N-2:0], sin_lsb_in};
   assign count_clamped = (count_in > CW'(N)) ? CW'(N) : count_in;
   assign shift_mode    = (mode_in == M_RIGHT) || (mode_in == M_LEFT);

   assign sout_lsb_out = q_out[0];
   assign sout_msb_out = q_out[N-1];

   // State, data, counter and flag registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset_ah_in) begin
         state    <= IDLE;
         q_out    <= '0;
         cnt      <= '0;
         dir_left <= 1'b0;
         busy_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         state    <= state_nxt;
         q_out    <= q_nxt;
         cnt      <= cnt_nxt;
         dir_left <= dir_left_nxt;
         busy_out <= busy_nxt;
         done_out <= done_nxt;
      end
   end

   // Next-state and datapath selection; done is a one-cycle pulse by default.
   always_comb begin
      state_nxt    = state;
      q_nxt        = q_out;
      cnt_nxt      = cnt;
      dir_left_nxt = dir_left;
      busy_nxt     = busy_out;
      done_nxt     = 1'b0;
      unique case (state)
         IDLE: begin
            if (en_in) begin
               if (start_in && shift_mode) begin
                  if (count_in == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     cnt_nxt      = count_clamped;
                     dir_left_nxt = mode_in[1];
                     busy_nxt     = 1'b1;
                     state_nxt    = BURST;
                  end
               end else begin
                  unique case (mode_in)
                     M_HOLD:  q_nxt = q_out;
                     M_RIGHT: q_nxt = q_shr;
                     M_LEFT:  q_nxt = q_shl;
                     M_LOAD:  q_nxt = d_in;
                     default: q_nxt = q_out;
                  endcase
               end
            end
         end
         BURST: begin
            if (en_in) begin
               q_nxt   = dir_left ? q_shl : q_shr;
               cnt_nxt = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
